// File: rtl/puf_seq_ctrl.sv
// puf_seq_ctrl: challenge sequencer for the read-write-collision PUF core.
// Runs RSP_W challenges at stepped addresses. Each challenge is evaluated
// TRIALS times and majority-voted to one response bit. The packed response
// word is delivered on a valid/ready handshake.
module puf_seq_ctrl #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned RSP_W     = 16,
   parameter int unsigned TRIALS    = 5,
   parameter int unsigned ADDR_STEP = 1,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] cha_data,
   input  logic [ADDR_W-1:0] cha_addr_base,
   output logic              busy,
   input  logic              core_available,
   output logic              core_gen_enable,
   output logic [DATA_W-1:0] core_cha_data,
   output logic [ADDR_W-1:0] core_cha_addr,
   input  logic              core_rsp_write,
   input  logic              core_rsp_clean,
   output logic [RSP_W-1:0]  rsp_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_err
);

   localparam int unsigned CNT_W = $clog2(TRIALS + 1);
   localparam int unsigned TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int unsigned IDX_W = (RSP_W > 1) ? $clog2(RSP_W) : 1;

   localparam logic [CNT_W-1:0]  TRIALS_C   = CNT_W'(TRIALS);
   localparam logic [CNT_W-1:0]  MAJ_C      = CNT_W'(TRIALS / 2);
   localparam logic [TMR_W-1:0]  TIMEOUT_C  = TMR_W'(TIMEOUT);
   localparam logic [IDX_W-1:0]  LAST_IDX_C = IDX_W'(RSP_W - 1);
   localparam logic [ADDR_W-1:0] STEP_C     = ADDR_W'(ADDR_STEP);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_VOTE,
      ST_DONE
   } state_t;

   state_t              state_q;
   logic [DATA_W-1:0]   data_q;
   logic [ADDR_W-1:0]   addr_q,  addr_d;
   logic [IDX_W-1:0]    idx_q;
   logic [CNT_W-1:0]    trial_q, trial_d;
   logic [CNT_W-1:0]    vote_q,  vote_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic [RSP_W-1:0]    rsp_q;
   logic                err_q;
   logic                busy_q;
   logic                valid_q;

   logic                write_only;
   logic                collide;
   logic                timed_out;
   logic                outcome;

   // Trial outcome decode and next values of the counters
   always_comb begin
      write_only = core_rsp_write & ~core_rsp_clean;
      collide    = core_rsp_write &  core_rsp_clean;
      timed_out  = ~core_rsp_write & ~core_rsp_clean & (timer_q == TIMEOUT_C);
      outcome    = core_rsp_write | core_rsp_clean | timed_out;
      vote_d     = vote_q + CNT_W'(write_only);
      trial_d    = trial_q + CNT_W'(1);
      timer_d    = timer_q + TMR_W'(1);
      addr_d     = addr_q + STEP_C;
   end

   // Sequencer FSM: issue, wait, vote per challenge, then hold the response
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         addr_q  <= '0;
         idx_q   <= '0;
         trial_q <= '0;
         vote_q  <= '0;
         timer_q <= '0;
         rsp_q   <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  data_q  <= cha_data;
                  addr_q  <= cha_addr_base;
                  rsp_q   <= '0;
                  err_q   <= 1'b0;
                  idx_q   <= '0;
                  trial_q <= '0;
                  vote_q  <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (core_available) begin
                  timer_q <= '0;
                  state_q <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (outcome) begin
                  vote_q  <= vote_d;
                  trial_q <= trial_d;
                  if (collide || timed_out) err_q <= 1'b1;
                  state_q <= (trial_d < TRIALS_C) ? ST_ISSUE : ST_VOTE;
               end else begin
                  timer_q <= timer_d;
               end
            end
            ST_VOTE: begin
               rsp_q[idx_q] <= (vote_q > MAJ_C);
               vote_q       <= '0;
               trial_q      <= '0;
               addr_q       <= addr_d;
               idx_q        <= idx_q + IDX_W'(1);
               if (idx_q == LAST_IDX_C) begin
                  valid_q <= 1'b1;
                  state_q <= ST_DONE;
               end else begin
                  state_q <= ST_ISSUE;
               end
            end
            ST_DONE: begin
               if (rsp_ready) begin
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Launch strobe is decoded from the ISSUE state so it coincides with the
   // accepting cycle; reset drops it together with the state register.
   assign core_gen_enable = (state_q == ST_ISSUE) && core_available;
   assign core_cha_data   = data_q;
   assign core_cha_addr   = addr_q;
   assign busy            = busy_q;
   assign rsp_data        = rsp_q;
   assign rsp_valid       = valid_q;
   assign rsp_err         = err_q;

endmodule

// File: tb/tb_puf_seq_ctrl.sv
// Testbench for puf_seq_ctrl: reacting core model driven cycle by cycle,
// expected response computed from per-trial outcome tables.
module tb_puf_seq_ctrl;

   localparam int RSP_W   = 4;
   localparam int TRIALS  = 3;
   localparam int TIMEOUT = 255;
   localparam int N       = RSP_W * TRIALS;
   localparam int T_W = 0, T_C = 1, T_B = 2, T_N = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start = 1'b0;
   logic [31:0]      cha_data = '0;
   logic [9:0]       cha_addr_base = '0;
   logic             busy;
   logic             core_available = 1'b0;
   logic             core_gen_enable;
   logic [31:0]      core_cha_data;
   logic [9:0]       core_cha_addr;
   logic             core_rsp_write = 1'b0;
   logic             core_rsp_clean = 1'b0;
   logic [RSP_W-1:0] rsp_data;
   logic             rsp_valid;
   logic             rsp_ready = 1'b0;
   logic             rsp_err;

   int checks = 0;
   int errors = 0;
   int typ [N];
   int lat [N];
   int gap [N];

   puf_seq_ctrl #(
      .DATA_W(32), .ADDR_W(10), .RSP_W(RSP_W), .TRIALS(TRIALS),
      .ADDR_STEP(1), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .cha_data(cha_data),
      .cha_addr_base(cha_addr_base), .busy(busy),
      .core_available(core_available), .core_gen_enable(core_gen_enable),
      .core_cha_data(core_cha_data), .core_cha_addr(core_cha_addr),
      .core_rsp_write(core_rsp_write), .core_rsp_clean(core_rsp_clean),
      .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic plan_random(input bit allow_err);
      for (int t = 0; t < N; t++) begin
         typ[t] = int'($urandom_range(0, 1));
         if (allow_err && ($urandom_range(0, 9) == 0)) typ[t] = int'($urandom_range(2, 3));
         lat[t] = int'($urandom_range(1, 4));
         gap[t] = int'($urandom_range(0, 3));
      end
      if (typ[N-1] == T_N) typ[N-1] = T_C;
   endtask

   // One full run: start, react as the core, check every launch, then the handshake
   task automatic run_case(input string nm, input logic [9:0] base, input logic [31:0] data,
                           input bit mid_start, input int rdy_delay);
      logic [RSP_W-1:0] er;
      logic ee;
      int votes, t, cyc, low_left, resp_cyc, last_out, gens, gen_prev, vcyc;
      bit pending, to_pending, got_valid;
      logic [9:0] ea;
      er = '0;
      ee = 1'b0;
      for (int i = 0; i < RSP_W; i++) begin
         votes = 0;
         for (int j = 0; j < TRIALS; j++) begin
            if (typ[i*TRIALS+j] == T_W) votes++;
            if (typ[i*TRIALS+j] >= T_B) ee = 1'b1;
         end
         er[i] = (votes * 2 > TRIALS);
      end
      @(negedge clk);
      start = 1'b1; cha_data = data; cha_addr_base = base;
      core_available = 1'b0; core_rsp_write = 1'b0; core_rsp_clean = 1'b0;
      t = 0; cyc = 0; pending = 0; to_pending = 0; low_left = gap[0];
      gens = 0; got_valid = 0; last_out = 0; gen_prev = 0; resp_cyc = 0; vcyc = 0;
      while (cyc < 5000 && !got_valid) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            start = 1'b0; cha_data = $urandom; cha_addr_base = 10'($urandom);
         end
         if (mid_start) start = (cyc == 7);
         core_rsp_write = 1'b0; core_rsp_clean = 1'b0; core_available = 1'b1;
         if (pending && !to_pending && cyc == resp_cyc) begin
            core_rsp_write = (typ[t-1] == T_W) || (typ[t-1] == T_B);
            core_rsp_clean = (typ[t-1] == T_C) || (typ[t-1] == T_B);
            pending  = 0;
            last_out = cyc;
            low_left = (t < N) ? gap[t] : 0;
         end else if (!pending && low_left > 0) begin
            core_available = 1'b0;
            low_left--;
            core_rsp_write = 1'($urandom);
            core_rsp_clean = 1'($urandom);
         end
         #1;
         if (cyc == 1) begin
            chk({nm, ".busy_start"}, busy, 1);
            chk({nm, ".rsp_clr"}, rsp_data, 0);
            chk({nm, ".err_clr"}, rsp_err, 0);
         end
         chk({nm, ".gen_unavail"}, core_gen_enable & ~core_available, 0);
         if (core_gen_enable) begin
            if (to_pending) begin
               chk({nm, ".timeout_len"},
                   (cyc - gen_prev >= TIMEOUT + 1) && (cyc - gen_prev <= TIMEOUT + 2), 1);
               to_pending = 0;
               pending = 0;
            end
            chk({nm, ".gen_overlap"}, pending, 0);
            chk({nm, ".gen_count"}, (t < N), 1);
            if (t < N) begin
               ea = 10'((int'(base) + t / TRIALS) % 1024);
               chk({nm, ".addr"}, core_cha_addr, ea);
               chk({nm, ".data"}, core_cha_data, data);
               pending    = 1;
               to_pending = (typ[t] == T_N);
               resp_cyc   = cyc + lat[t];
            end
            gen_prev = cyc;
            gens++;
            t++;
         end
         if (rsp_valid) begin
            got_valid = 1;
            vcyc = cyc;
         end
      end
      chk({nm, ".valid_seen"}, got_valid, 1);
      chk({nm, ".gens"}, gens, N);
      if (typ[N-1] != T_N) chk({nm, ".valid_lat"}, vcyc - last_out, 2);
      chk({nm, ".rsp_data"}, rsp_data, er);
      chk({nm, ".rsp_err"}, rsp_err, ee);
      chk({nm, ".busy_done"}, busy, 1);
      for (int k = 0; k < rdy_delay; k++) begin
         @(negedge clk);
         start = 1'($urandom);
         core_rsp_write = 1'($urandom);
         core_rsp_clean = 1'($urandom);
         #1;
         chk({nm, ".hold_valid"}, rsp_valid, 1);
         chk({nm, ".hold_data"}, rsp_data, er);
         chk({nm, ".hold_err"}, rsp_err, ee);
      end
      @(negedge clk);
      start = 1'b0; core_rsp_write = 1'b0; core_rsp_clean = 1'b0; rsp_ready = 1'b1;
      #1 chk({nm, ".xfer_valid"}, rsp_valid, 1);
      @(negedge clk);
      rsp_ready = 1'b0;
      #1;
      chk({nm, ".post_valid"}, rsp_valid, 0);
      chk({nm, ".post_busy"}, busy, 0);
      chk({nm, ".retain"}, rsp_data, er);
   endtask

   initial begin
      #1;
      chk("reset.busy", busy, 0);
      chk("reset.valid", rsp_valid, 0);
      chk("reset.gen", core_gen_enable, 0);
      chk("reset.data", rsp_data, 0);
      chk("reset.err", rsp_err, 0);
      chk("reset.addr", core_cha_addr, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // Even addresses answer write, odd answer clean, 3-cycle latency
      for (int t = 0; t < N; t++) begin
         typ[t] = ((t / TRIALS) % 2 == 0) ? T_W : T_C;
         lat[t] = 3;
         gap[t] = 0;
      end
      run_case("basic", 10'h000, 32'hDEADBEEF, 0, 0);

      // Majority voting, mid-run start, core unavailable for 5 cycles
      plan_random(0);
      typ[0] = T_W; typ[1] = T_C; typ[2] = T_W;
      typ[3] = T_C; typ[4] = T_C; typ[5] = T_W;
      gap[3] = 5;
      run_case("major", 10'h0C4, 32'h12345678, 1, 0);

      // Address wrap
      plan_random(0);
      run_case("wrap", 10'h3FE, 32'hA5A5_0F0F, 0, 1);

      // Collide and timeout trials, response held for 10 cycles
      plan_random(0);
      typ[4] = T_B;
      typ[7] = T_N;
      run_case("errs", 10'h100, 32'h0BAD_F00D, 0, 10);

      for (int r = 0; r < 3; r++) begin
         plan_random(1);
         run_case("rand", 10'($urandom), $urandom, 1'($urandom), int'($urandom_range(0, 5)));
      end

      // Reset while waiting on the core
      @(negedge clk);
      start = 1'b1; cha_data = 32'h5555_AAAA; cha_addr_base = 10'h155; core_available = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1 chk("rstw.gen_issue", core_gen_enable, 1);
      @(negedge clk);
      #1 chk("rstw.busy_wait", busy, 1);
      #2 rst = 1'b0;
      #1;
      chk("rstw.busy", busy, 0);
      chk("rstw.valid", rsp_valid, 0);
      chk("rstw.gen", core_gen_enable, 0);
      chk("rstw.data", rsp_data, 0);
      chk("rstw.addr", core_cha_addr, 0);
      @(negedge clk);
      rst = 1'b1;

      // Reset while a launch strobe is high
      @(negedge clk);
      start = 1'b1; cha_addr_base = 10'h077;
      @(negedge clk);
      start = 1'b0;
      #1 chk("rsti.gen_issue", core_gen_enable, 1);
      rst = 1'b0;
      #1 chk("rsti.gen", core_gen_enable, 0);
      @(negedge clk);
      rst = 1'b1;

      // Clean run from a new base after reset
      plan_random(0);
      run_case("after_rst", 10'h2A0, 32'hCAFE_0001, 0, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
